adt7410_i2c_target: RTL
=======================

Name: adt7410_i2c_target

Overview:
- Synthesizable I2C target (responder) that emulates the ADT7410 temperature sensor register map. It is the far end of the I2C master transactions issued by the sensor-application FSMs.
- Used in on-chip loopback and in FPGA sensor-emulation builds.
- Samples SCL/SDA through synchronizers and drives SDA open-drain only: it pulls low or releases.
- The temperature value comes from a parallel input. The config register is exposed to the fabric.

Parameters:
- DevAddr, 7'h48, 7-bit I2C device address.
- IdValue, 8'hCB, value returned for register 0x0B.

Ports:
- Clk_i  in  1  system clock; must be at least 16x the SCL rate.
- Reset_i  in  1  asynchronous, active-high reset.
- SCL_i  in  1  raw SCL line.
- SDA_i  in  1  raw SDA line.
- SDAPullDown_o  in/out: output  1  1 = drive SDA low, 0 = release.
- Temperature_i  in  16  new conversion result.
- TempValid_i  in  1  single-cycle strobe; loads Temperature_i.
- Config_o  out  8  config register (reg 0x03).
- Busy_o  out  1  1 while this target is addressed (from address ACK until STOP/START).
- ReadDone_o  out  1  one-cycle pulse when temp LSB (reg 0x01) read is acknowledged or NACKed by the master.

Behaviour:
- **Reset values:** SDAPullDown_o=0, Config_o=8'h00, Busy_o=0, ReadDone_o=0, pointer=0x00, temp register=16'h0000, RDY_n (status bit7)=1, state=Idle.
- **Input sync:** 2-flop synchronizer per line, followed by one delay flop for edge detect. A line event is therefore seen 3 cycles after the pin changes.
- **Line events:**
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - Data is sampled on SCL rise.
  - SDA is updated on the first clock after an SCL fall has been detected.
- **START/STOP priority:** START (including repeated START) and STOP take priority over any state.
  - START → Addr, bit count cleared, SDA released.
  - STOP → Idle, SDA released, Busy_o=0.
- **States:**
  - Idle → Addr on START.
  - Addr: shift 8 bits MSB-first.
    - Address matches DevAddr → AddrAck; latch R/W.
    - No match → Ignore (SDA released until START/STOP).
  - AddrAck: pull SDA low for the 9th SCL pulse; Busy_o=1.
    - On read (R/W=1): copy the temp register into a 16-bit shadow, then → RdData.
    - On write: → Ptr.
  - Ptr: receive 8 bits into pointer → PtrAck (always ACK) → WrData.
  - WrData: receive a byte → WrAck.
    - Pointer 0x03: write Config_o; the new value is visible the cycle after the 8th bit is sampled.
    - Any other pointer: byte discarded, still ACKed.
    - Pointer unchanged after the write.
  - RdData: drive the 8 bits of the addressed register MSB-first.
    - A 1 bit releases SDA; a 0 bit pulls low.
    - On the 9th SCL fall, SDA is released → RdAck.
  - RdAck: sample the master bit on SCL rise.
    - ACK (0) → RdData with next byte.
    - NACK (1) → Ignore.
- **Read map:**
  - 0x00 = shadow[15:8]
  - 0x01 = shadow[7:0]
  - 0x02 = {RDY_n,7'b0}
  - 0x03 = Config_o
  - 0x0B = IdValue
  - any other pointer = 8'h00
- **Pointer auto-increment:** only 0x00→0x01 and 0x01→0x00, after each read byte. Other pointers do not increment.
- **Shadow coherence:** a TempValid_i arriving mid-read updates the temp register but not the shadow. MSB/LSB of a single transaction are always from the same conversion.
- **RDY_n:**
  - TempValid_i clears RDY_n to 0.
  - Completing the reg 0x01 read byte sets RDY_n to 1 and pulses ReadDone_o.
  - TempValid_i in the same cycle as ReadDone_o: TempValid_i wins (RDY_n=0).
- **Clock stretching:** not supported.
- **Reset mid-transfer:** asynchronous return to reset values; SDA released immediately.

Decomposition:
- Shared package (adt7410_pkg):
  - register address constants: RegTempMsb=0x00, RegTempLsb=0x01, RegStatus=0x02, RegConfig=0x03, RegId=0x0B.
  - state enumeration.
  - default address / ID constants.
- One sub-module, i2c_line_sync: synchronizers, edge detect, START/STOP/SCL-rise/SCL-fall pulses.
- The protocol FSM and register file stay in adt7410_i2c_target.

Test Plan:
- **Pointer-set then read:**
  - Stimulus: TempValid_i with Temperature_i=16'h0C80; write 0x90,0x00; repeated START; read 0x91 two bytes (ACK, NACK).
  - Required: data 0x0C,0x80; ReadDone_o one pulse; status then reads 0x80.
- **Wrong address:**
  - Stimulus: START, 0x92 (addr 0x49).
  - Required: no ACK (SDA high on 9th bit); Busy_o stays 0; bus ignored until STOP.
- **Config write/readback:**
  - Stimulus: write 0x90,0x03,0xA5.
  - Required: three ACKs; Config_o=8'hA5 one cycle after 8th data bit; read 0x03 returns 0xA5; pointer stays 0x03.
- **Coherence:**
  - Stimulus: reading from 0x00, with TempValid_i=16'h1234 between MSB and LSB byte while shadow holds 16'h0C80.
  - Required: LSB returns 0x80; next transaction returns 0x12,0x34; RDY_n=0 after the collision cycle.
- **ID and unmapped:**
  - Stimulus: pointer 0x0B read; pointer 0x07 read.
  - Required: 0xCB; 0x00 with no pointer increment.
- **Reset mid-read:**
  - Stimulus: assert Reset_i while driving a 0 bit.
  - Required: SDAPullDown_o=0 asynchronously (same cycle); Config_o=0; next valid transaction works.

Source files
------------

// File: rtl/adt7410_pkg.sv
// ADT7410 target emulation: register map constants and protocol states.
// Shared by the line synchronizer and the protocol FSM.
package adt7410_pkg;

  localparam logic [7:0] RegTempMsb = 8'h00;
  localparam logic [7:0] RegTempLsb = 8'h01;
  localparam logic [7:0] RegStatus  = 8'h02;
  localparam logic [7:0] RegConfig  = 8'h03;
  localparam logic [7:0] RegId      = 8'h0B;

  localparam logic [6:0] DefDevAddr = 7'h48;
  localparam logic [7:0] DefIdValue = 8'hCB;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  // Only the two temperature bytes toggle into each other.
  function automatic logic [7:0] ptr_step(input logic [7:0] p);
    logic [7:0] r;
    r = p;
    if (p == RegTempMsb) r = RegTempLsb;
    else if (p == RegTempLsb) r = RegTempMsb;
    return r;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with START/STOP and SCL edge pulses.
// Events appear three clocks after the pin changes.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic start,
  output logic stop,
  output logic scl_rise,
  output logic scl_fall
);

  // [0],[1] synchronizer, [2] edge-detect delay
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_s    = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/adt7410_i2c_target.sv
// I2C target emulating the ADT7410 register map.
// SDA is open-drain: SDAPullDown_o=1 pulls the line low.
module adt7410_i2c_target
  import adt7410_pkg::*;
#(
  parameter logic [6:0] DevAddr = DefDevAddr,
  parameter logic [7:0] IdValue = DefIdValue
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        SCL_i,
  input  logic        SDA_i,
  output logic        SDAPullDown_o,
  input  logic [15:0] Temperature_i,
  input  logic        TempValid_i,
  output logic [7:0]  Config_o,
  output logic        Busy_o,
  output logic        ReadDone_o
);

  logic sda_s;
  logic start_p;
  logic stop_p;
  logic scl_rise;
  logic scl_fall;

  i2c_line_sync u_sync (
    .clk      (Clk_i),
    .rst      (Reset_i),
    .scl      (SCL_i),
    .sda      (SDA_i),
    .sda_s    (sda_s),
    .start    (start_p),
    .stop     (stop_p),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall)
  );

  i2c_state_e  state_q;
  i2c_state_e  state_d;
  logic [3:0]  cnt_q;
  logic [7:0]  rx_q;
  logic [7:0]  tx_q;
  logic [7:0]  ptr_q;
  logic [7:0]  cfg_q;
  logic [15:0] temp_q;
  logic [15:0] shadow_q;
  logic        rdy_n_q;
  logic        rw_q;
  logic        pd_q;
  logic        busy_q;
  logic        done_q;

  function automatic logic [7:0] rd_byte(
    input logic [7:0]  p,
    input logic [15:0] sh,
    input logic        rdy_n,
    input logic [7:0]  cfg
  );
    logic [7:0] r;
    case (p)
      RegTempMsb: r = sh[15:8];
      RegTempLsb: r = sh[7:0];
      RegStatus:  r = {rdy_n, 7'b0};
      RegConfig:  r = cfg;
      RegId:      r = IdValue;
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

  logic [7:0] rx_next;
  logic [7:0] ptr_inc;
  logic [7:0] first_byte;
  logic [7:0] next_byte;
  logic       last_bit;
  logic       addr_hit;
  logic       ack_end;

  assign rx_next    = {rx_q[6:0], sda_s};
  assign ptr_inc    = ptr_step(ptr_q);
  assign last_bit   = (cnt_q == 4'd7);
  assign addr_hit   = (rx_next[7:1] == DevAddr);
  assign ack_end    = (cnt_q != 4'd0);
  // First byte of a read comes from the live register, copied to shadow now.
  assign first_byte = rd_byte(ptr_q, temp_q, rdy_n_q, cfg_q);
  assign next_byte  = rd_byte(ptr_inc, shadow_q, rdy_n_q, cfg_q);

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_p) begin
      state_d = ST_ADDR;
    end else if (stop_p) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR:
          if (scl_rise && last_bit)
            state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:
          if (scl_fall && ack_end)
            state_d = rw_q ? ST_RD_DATA : ST_PTR;
        ST_PTR:
          if (scl_rise && last_bit) state_d = ST_PTR_ACK;
        ST_PTR_ACK:
          if (scl_fall && ack_end) state_d = ST_WR_DATA;
        ST_WR_DATA:
          if (scl_rise && last_bit) state_d = ST_WR_ACK;
        ST_WR_ACK:
          if (scl_fall && ack_end) state_d = ST_WR_DATA;
        ST_RD_DATA:
          if (scl_fall && cnt_q == 4'd8) state_d = ST_RD_ACK;
        ST_RD_ACK:
          if (scl_rise) state_d = sda_s ? ST_IGNORE : ST_RD_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      ptr_q    <= RegTempMsb;
      cfg_q    <= '0;
      temp_q   <= '0;
      shadow_q <= '0;
      rdy_n_q  <= 1'b1;
      rw_q     <= 1'b0;
      pd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (TempValid_i) begin
        temp_q  <= Temperature_i;
        rdy_n_q <= 1'b0;
      end
      if (start_p || stop_p) begin
        cnt_q  <= '0;
        pd_q   <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WR_DATA: begin
            if (scl_rise) begin
              rx_q  <= rx_next;
              cnt_q <= last_bit ? 4'd0 : cnt_q + 4'd1;
              if (last_bit) begin
                if (state_q == ST_ADDR && addr_hit) begin
                  busy_q <= 1'b1;
                  rw_q   <= sda_s;
                end
                if (state_q == ST_PTR) ptr_q <= rx_next;
                if (state_q == ST_WR_DATA && ptr_q == RegConfig)
                  cfg_q <= rx_next;
              end
            end
          end
          // cnt 0: ACK not yet driven; cnt 1: ACK pulse in progress
          ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_end) begin
                pd_q  <= 1'b1;
                cnt_q <= 4'd1;
              end else if (state_q == ST_ADDR_ACK && rw_q) begin
                shadow_q <= temp_q;
                pd_q     <= ~first_byte[7];
                tx_q     <= {first_byte[6:0], 1'b0};
                cnt_q    <= 4'd1;
              end else begin
                pd_q  <= 1'b0;
                cnt_q <= 4'd0;
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                pd_q  <= 1'b0;
                cnt_q <= 4'd0;
              end else begin
                pd_q  <= ~tx_q[7];
                tx_q  <= {tx_q[6:0], 1'b0};
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              ptr_q <= ptr_inc;
              tx_q  <= next_byte;
              cnt_q <= 4'd0;
              if (ptr_q == RegTempLsb) begin
                done_q <= 1'b1;
                if (!TempValid_i) rdy_n_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SDAPullDown_o = pd_q;
  assign Config_o      = cfg_q;
  assign Busy_o        = busy_q;
  assign ReadDone_o    = done_q;

endmodule
